rgb_sobel: RTL and testbench
============================

// Module: rgb_sobel
// PURPOSE
//  Streaming 3x3 Sobel edge detector that consumes the RGB565 pixel stream of rgb_gauss
//  (out_vs/out_de/out_data). It converts each pixel to 8-bit luma, builds a 3x3 window
//  from two on-chip line buffers and emits a binary or grey-level edge map as RGB565.
//  Sits directly downstream of rgb_gauss, ahead of the frame capture / display sink.
// PARAMETERS
//  H_ACTIVE   800  active pixels per line; sets line-buffer depth and column-counter range
//  RGB_WIDTH  16   pixel width; only 16 (RGB565) is supported
//  MODE       0    0: binary output (mag > thresh -> 16'hFFFF, else 16'h0000);
//                  1: grey magnitude output {mag[7:3],mag[7:2],mag[7:3]}
// PORTS
//  clk       in   1   pixel clock
//  rst_n     in   1   asynchronous, active-low reset
//  thresh    in   8   edge threshold; sampled on the in_vs rising edge
//  in_hs     in   1   line sync, delay-matched only
//  in_vs     in   1   frame sync; rising edge = frame start
//  in_de     in   1   pixel valid
//  in_data   in   16  RGB565 pixel
//  out_hs    out  1   in_hs delayed by LAT
//  out_vs    out  1   in_vs delayed by LAT
//  out_de    out  1   in_de delayed by LAT
//  out_data  out  16  edge pixel, RGB565
// BEHAVIOUR
//  - Reset (async, rst_n=0): out_hs/out_vs/out_de=0, out_data=16'h0000; counters, window regs,
//    pipeline regs, thr_q and frame_ok clear to 0. Line-buffer RAM is not reset.
//  - LAT = 4 clocks, fixed: S1 luma reg; S2 line-buffer read + window shift;
//    S3 Gx/Gy; S4 |Gx|+|Gy|, saturate, threshold, output reg. Syncs use a matching 4-deep delay.
//  - Luma: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]};
//    Y=(77*R8+150*G8+29*B8)>>8, 16-bit intermediate; white -> 255, black -> 0.
//  - col: increments on each S1-valid pixel and saturates at H_ACTIVE-1.
//    Clears on the falling edge of de. Gaps in de within a line hold col and the window.
//  - row: increments on de falling edge, saturates at 2047, clears on in_vs rising edge.
//  - Line buffers LB0/LB1 (H_ACTIVE x 8): read-before-write at address col.
//    LB1<=LB0[col], LB0<=Y. Pixels beyond H_ACTIVE-1 rewrite the last entry.
//  - Window P[r][c] (r,c in 1..3): row 3 = current line, column 3 = newest pixel.
//    Output for input pixel (row,col) is the window whose bottom-right pixel is (row,col).
//    This window is centred on (row-1,col-1), so the map is shifted by 1 line and 1 pixel.
//  - Gx=(P13+2P23+P33)-(P11+2P21+P31); Gy=(P31+2P32+P33)-(P11+2P12+P13); 11-bit signed.
//    sum=|Gx|+|Gy| (11-bit, max 2040); mag=(sum>255)?255:sum[7:0].
//  - Border: row<2 or col<2 -> out_data=16'h0000 while out_de=1.
//  - frame_ok: 0 after reset, set on first in_vs rising edge. While 0, out_data=0.
//    Reset mid-frame therefore blanks the rest of that frame. Syncs still pass through.
//  - thr_q<=thresh on each in_vs rising edge. Changes mid-frame take effect next frame.
//  - out_data=0 whenever out_de=0.
// TESTING
//  1 Flat 800x4 frame, all 16'h8410 -> 3200 out_de cycles, each exactly 4 clk after in_de;
//    all out_data=0.
//  2 MODE0, thresh=64; cols 0..399 black, cols 400..799 white; 6 rows ->
//    rows>=2: out_data=16'hFFFF at cols 400,401 only, 0 elsewhere; rows 0,1 all 0.
//  3 MODE1; single white pixel at (10,10) on black -> 16'hFFFF at outputs
//    (10..12,10..12) except (11,11)=0; all other outputs 0.
//  4 Sync timing with de gaps (2-clk hole mid-line) -> out_hs/vs/de equal inputs delayed 4;
//    window holds and the edge result is unchanged vs gap-free.
//  5 rst_n low at row 3 col 100 -> all outputs 0 within the same cycle. After release,
//    out_data=0 until next in_vs rise; the following frame matches test 2.
//  6 thresh 64->255 mid-frame on test-2 image -> current frame unchanged;
//    next frame all 0 (255 is not > 255).

Source files
------------

// File: rtl/rgb_sobel.sv
// rgb_sobel: streaming 3x3 Sobel edge detector on an RGB565 video stream.
// Luma conversion, two line buffers, 3x3 window, |Gx|+|Gy| magnitude and
// binary/grey output; syncs pass through a matching 4-clock delay.
module rgb_sobel #(
  parameter int unsigned H_ACTIVE  = 800,
  parameter int unsigned RGB_WIDTH = 16,
  parameter int unsigned MODE      = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           thresh,
  input  logic                 in_hs,
  input  logic                 in_vs,
  input  logic                 in_de,
  input  logic [RGB_WIDTH-1:0] in_data,
  output logic                 out_hs,
  output logic                 out_vs,
  output logic                 out_de,
  output logic [RGB_WIDTH-1:0] out_data
);

  localparam int unsigned COL_W  = $clog2(H_ACTIVE);
  localparam int unsigned ROW_W  = 11;
  localparam int unsigned LUMA_W = 8;
  localparam int unsigned G_W    = 11;

  // sync delay lines, frame control and line position
  logic [3:0]       hs_dly, vs_dly;
  logic             vs_q, frame_ok, full_q;
  logic [7:0]       thr_q;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  // pipeline stages
  logic [LUMA_W-1:0]          y_q;
  logic                       s1_de, s2_de, s3_de;
  logic [2:0][2:0][LUMA_W-1:0] win;
  logic [ROW_W-1:0]           s2_row;
  logic [COL_W-1:0]           s2_col;
  logic signed [G_W-1:0]      gx_q, gy_q;
  logic                       s3_bord;

  // line buffers (not reset)
  logic [LUMA_W-1:0] lb0 [H_ACTIVE];
  logic [LUMA_W-1:0] lb1 [H_ACTIVE];

  logic                  vs_rise_c, line_end_c;
  logic [LUMA_W-1:0]     r8_c, g8_c, b8_c;
  logic [15:0]           y_sum_c;
  logic signed [G_W-1:0] gx_c, gy_c;
  logic [G_W-1:0]        ax_c, ay_c, sum_c;
  logic [7:0]            mag_c;
  logic [15:0]           pix_c;

  function automatic logic signed [G_W-1:0] ext(input logic [LUMA_W-1:0] v);
    return signed'({3'b000, v});
  endfunction

  assign vs_rise_c = in_vs & ~vs_q;
  // A de fall ends the line only once the last column was reached; earlier gaps just hold.
  assign line_end_c = s2_de & ~s1_de & full_q;

  // RGB565 -> 8-bit luma
  always_comb begin
    r8_c    = {in_data[15:11], in_data[15:13]};
    g8_c    = {in_data[10:5],  in_data[10:9]};
    b8_c    = {in_data[4:0],   in_data[4:2]};
    y_sum_c = 16'(r8_c) * 16'd77 + 16'(g8_c) * 16'd150 + 16'(b8_c) * 16'd29;
  end

  // Sobel gradients over the window; P[r][c] maps to win[r-1][c-1]
  always_comb begin
    gx_c = (ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2]))
         - (ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]));
    gy_c = (ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2]))
         - (ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(win[0][2]));
  end

  // magnitude, saturation and output pixel formatting
  always_comb begin
    ax_c  = gx_q[G_W-1] ? G_W'(-gx_q) : G_W'(gx_q);
    ay_c  = gy_q[G_W-1] ? G_W'(-gy_q) : G_W'(gy_q);
    sum_c = ax_c + ay_c;
    mag_c = (sum_c > G_W'(255)) ? 8'hFF : sum_c[7:0];
    if (MODE == 1) pix_c = {mag_c[7:3], mag_c[7:2], mag_c[7:3]};
    else           pix_c = (mag_c > thr_q) ? 16'hFFFF : 16'h0000;
  end

  // 4-deep delay for the pass-through syncs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_dly <= '0;
      vs_dly <= '0;
    end else begin
      hs_dly <= {hs_dly[2:0], in_hs};
      vs_dly <= {vs_dly[2:0], in_vs};
    end
  end

  assign out_hs = hs_dly[3];
  assign out_vs = vs_dly[3];

  // frame start: latch threshold, enable output, restart position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q     <= 1'b0;
      thr_q    <= '0;
      frame_ok <= 1'b0;
      col      <= '0;
      row      <= '0;
      full_q   <= 1'b0;
    end else begin
      vs_q <= in_vs;
      if (vs_rise_c) begin
        thr_q    <= thresh;
        frame_ok <= 1'b1;
        col      <= '0;
        row      <= '0;
        full_q   <= 1'b0;
      end else if (line_end_c) begin
        col    <= '0;
        full_q <= 1'b0;
        if (row != {ROW_W{1'b1}}) row <= row + 1'b1;
      end else if (s1_de) begin
        if (col == COL_W'(H_ACTIVE - 1)) full_q <= 1'b1;
        else                             col    <= col + 1'b1;
      end
    end
  end

  // S1: luma register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q   <= '0;
      s1_de <= 1'b0;
    end else begin
      y_q   <= y_sum_c[15:8];
      s1_de <= in_de;
    end
  end

  // line buffers: read-before-write at col, LB0 -> LB1 cascade
  always_ff @(posedge clk) begin
    if (s1_de) begin
      lb0[col] <= y_q;
      lb1[col] <= lb0[col];
    end
  end

  // S2: window shift on valid pixels, hold during de gaps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win    <= '0;
      s2_de  <= 1'b0;
      s2_row <= '0;
      s2_col <= '0;
    end else begin
      s2_de <= s1_de;
      if (s1_de) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb1[col];
        win[1][2] <= lb0[col];
        win[2][2] <= y_q;
        s2_row    <= row;
        s2_col    <= col;
      end
    end
  end

  // S3: gradients and border flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx_q    <= '0;
      gy_q    <= '0;
      s3_de   <= 1'b0;
      s3_bord <= 1'b0;
    end else begin
      gx_q    <= gx_c;
      gy_q    <= gy_c;
      s3_de   <= s2_de;
      s3_bord <= (s2_row < ROW_W'(2)) || (s2_col < COL_W'(2));
    end
  end

  // S4: output register, blanked outside valid interior pixels of an enabled frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_de   <= 1'b0;
      out_data <= '0;
    end else begin
      out_de   <= s3_de;
      out_data <= (s3_de && frame_ok && !s3_bord) ? RGB_WIDTH'(pix_c) : '0;
    end
  end

endmodule

// File: tb/tb_rgb_sobel.sv
// tb_rgb_sobel: directed frames against hand-derived edge maps for MODE 0 and MODE 1.
module tb_rgb_sobel;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  thresh = '0;
  logic        in_hs = 1'b0, in_vs = 1'b0, in_de = 1'b0;
  logic [15:0] in_data = '0;
  logic        o0_hs, o0_vs, o0_de, o1_hs, o1_vs, o1_de;
  logic [15:0] o0_data, o1_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cur_pat = 0, cur_row = 0, cur_col = 0;
  bit frame_ok_b = 1'b0;
  int frame_thr = 0;
  int de_cnt = 0, hit0 = 0, hit1 = 0;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [15:0] e0;
    logic [15:0] e1;
  } ent_t;
  ent_t hist [4];

  rgb_sobel #(.H_ACTIVE(800), .RGB_WIDTH(16), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .thresh(thresh), .in_hs(in_hs), .in_vs(in_vs),
    .in_de(in_de), .in_data(in_data), .out_hs(o0_hs), .out_vs(o0_vs),
    .out_de(o0_de), .out_data(o0_data));

  rgb_sobel #(.H_ACTIVE(800), .RGB_WIDTH(16), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .thresh(thresh), .in_hs(in_hs), .in_vs(in_vs),
    .in_de(in_de), .in_data(in_data), .out_hs(o1_hs), .out_vs(o1_vs),
    .out_de(o1_de), .out_data(o1_data));

  always #5 clk = ~clk;

  // input image: 0 flat grey, 1 black/white split at col 400, 2 single white dot at (10,10)
  function automatic logic [15:0] pat_in(int p, int r, int c);
    case (p)
      0:       return 16'h8410;
      1:       return (c >= 400) ? 16'hFFFF : 16'h0000;
      default: return (r == 10 && c == 10) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  // expected edge map for output position (r,c); every edge here has magnitude 255
  function automatic logic [15:0] pat_out(int p, int r, int c);
    case (p)
      0:       return 16'h0000;
      1:       return (r >= 2 && (c == 400 || c == 401)) ? 16'hFFFF : 16'h0000;
      default: return (r >= 10 && r <= 12 && c >= 10 && c <= 12 && !(r == 11 && c == 11))
                      ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  function automatic ent_t mk_ent();
    ent_t e;
    e.de = in_de;
    e.hs = in_hs;
    e.vs = in_vs;
    e.e1 = (in_de && frame_ok_b) ? pat_out(cur_pat, cur_row, cur_col) : 16'h0000;
    e.e0 = (frame_thr < 255) ? e.e1 : 16'h0000;
    return e;
  endfunction

  // expected outputs: inputs seen at each edge, 4 clocks old at the output
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) hist[i] <= '0;
    end else begin
      hist[0] <= mk_ent();
      hist[1] <= hist[0];
      hist[2] <= hist[1];
      hist[3] <= hist[2];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t row=%0d col=%0d)",
               tag, got, exp, $time, cur_row, cur_col);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check("hs0",   32'(o0_hs),   32'(hist[3].hs));
    check("vs0",   32'(o0_vs),   32'(hist[3].vs));
    check("de0",   32'(o0_de),   32'(hist[3].de));
    check("data0", 32'(o0_data), 32'(hist[3].e0));
    check("hs1",   32'(o1_hs),   32'(hist[3].hs));
    check("vs1",   32'(o1_vs),   32'(hist[3].vs));
    check("de1",   32'(o1_de),   32'(hist[3].de));
    check("data1", 32'(o1_data), 32'(hist[3].e1));
    if (o0_de) de_cnt++;
    if (o0_data == 16'hFFFF) hit0++;
    if (o1_data == 16'hFFFF) hit1++;
  endtask

  task automatic drive(input bit de, input bit hs, input bit vs, input logic [15:0] d,
                       input int r, input int c);
    sample();
    @(posedge clk);
    #1;
    in_de   = de;
    in_hs   = hs;
    in_vs   = vs;
    in_data = d;
    cur_row = r;
    cur_col = c;
  endtask

  task automatic run_frame(input int pat, input int rows, input bit gap, input int thr0,
                           input int thr1, input int rst_r, input int rst_c);
    cur_pat = pat;
    thresh  = 8'(thr0);
    drive(1'b0, 1'b0, 1'b1, 16'h0, 0, 0);
    frame_ok_b = 1'b1;
    frame_thr  = thr0;
    repeat (2) drive(1'b0, 1'b0, 1'b1, 16'h0, 0, 0);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 16'h0, 0, 0);
    for (int r = 0; r < rows; r++) begin
      if (r == 2) thresh = 8'(thr1);
      repeat (2) drive(1'b0, 1'b1, 1'b0, 16'h0, r, 0);
      repeat (2) drive(1'b0, 1'b0, 1'b0, 16'h0, r, 0);
      for (int c = 0; c < 800; c++) begin
        if (gap && c == 300) repeat (2) drive(1'b0, 1'b0, 1'b0, 16'h0, r, c);
        drive(1'b1, 1'b0, 1'b0, pat_in(pat, r, c), r, c);
        if (r == rst_r && c == rst_c) begin
          rst_n = 1'b0;
          frame_ok_b = 1'b0;
          #1;
          check("rst_async_de0",   32'(o0_de),   32'h0);
          check("rst_async_data0", 32'(o0_data), 32'h0);
          check("rst_async_de1",   32'(o1_de),   32'h0);
        end
        if (r == rst_r && c == rst_c + 3) rst_n = 1'b1;
      end
      repeat (4) drive(1'b0, 1'b0, 1'b0, 16'h0, r, 0);
    end
    repeat (4) drive(1'b0, 1'b0, 1'b0, 16'h0, 0, 0);
  endtask

  initial begin
    int d0, h0, h1;
    repeat (3) drive(1'b0, 1'b0, 1'b0, 16'h0, 0, 0);
    check("reset_de",   32'(o0_de),   32'h0);
    check("reset_data", 32'(o0_data), 32'h0);
    check("reset_vs",   32'(o1_vs),   32'h0);
    rst_n = 1'b1;
    repeat (3) drive(1'b0, 1'b0, 1'b0, 16'h0, 0, 0);

    // flat grey frame
    d0 = de_cnt; h0 = hit0;
    run_frame(0, 4, 1'b0, 64, 64, -1, -1);
    check("t1_de_count", 32'(de_cnt - d0), 32'd3200);
    check("t1_hits0",    32'(hit0 - h0),   32'd0);

    // vertical black/white edge
    h0 = hit0; h1 = hit1;
    run_frame(1, 6, 1'b0, 64, 64, -1, -1);
    check("t2_hits0", 32'(hit0 - h0), 32'd8);
    check("t2_hits1", 32'(hit1 - h1), 32'd8);

    // single white dot
    h0 = hit0; h1 = hit1;
    run_frame(2, 13, 1'b0, 64, 64, -1, -1);
    check("t3_hits0", 32'(hit0 - h0), 32'd8);
    check("t3_hits1", 32'(hit1 - h1), 32'd8);

    // edge frame with a 2-clock de hole in every line
    h0 = hit0; h1 = hit1;
    run_frame(1, 6, 1'b1, 64, 64, -1, -1);
    check("t4_hits0", 32'(hit0 - h0), 32'd8);
    check("t4_hits1", 32'(hit1 - h1), 32'd8);

    // reset at row 3 col 100, then a clean frame
    h0 = hit0;
    run_frame(1, 6, 1'b0, 64, 64, 3, 100);
    check("t5a_hits0", 32'(hit0 - h0), 32'd2);
    h0 = hit0; h1 = hit1;
    run_frame(1, 6, 1'b0, 64, 64, -1, -1);
    check("t5b_hits0", 32'(hit0 - h0), 32'd8);
    check("t5b_hits1", 32'(hit1 - h1), 32'd8);

    // threshold 64 -> 255 mid-frame takes effect only on the next frame
    h0 = hit0; h1 = hit1;
    run_frame(1, 6, 1'b0, 64, 255, -1, -1);
    check("t6a_hits0", 32'(hit0 - h0), 32'd8);
    check("t6a_hits1", 32'(hit1 - h1), 32'd8);
    h0 = hit0; h1 = hit1;
    run_frame(1, 6, 1'b0, 255, 255, -1, -1);
    check("t6b_hits0", 32'(hit0 - h0), 32'd0);
    check("t6b_hits1", 32'(hit1 - h1), 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
